prio_code_decoder: RTL and testbench

- Receiver-side counterpart of the 8-3 priority encoder with all-zero flag and the ones counter.
- Accepts a frame of encoder code words, one word per handshake, highest-priority index first.
- Decodes each word 3-to-8 and accumulates the one-hot bits to rebuild the original 8-bit request vector.
- Presents the rebuilt vector with its ones count and protocol-error flags on a valid/ready output.

---
 rtl/prio_code_decoder.sv | 123 ++++++++++++
 tb/tb_prio_code_decoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/prio_code_decoder.sv
// Priority-code frame decoder: rebuilds an 8-bit request vector from a frame
// of priority-encoder code words, and reports its ones count and protocol errors.
module prio_code_decoder #(
    parameter int CHECK_ORDER = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_code,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_vec,
    output logic [3:0] out_count,
    output logic       out_order_err,
    output logic       out_zero_err
);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t     state;
    logic [7:0] acc;
    logic       order_err;
    logic       zero_err;
    logic [2:0] prev_idx;
    logic       first;

    logic [2:0] idx;
    logic       all_zero;
    logic       accept;
    logic [7:0] acc_nxt;
    logic       order_err_nxt;
    logic       zero_err_nxt;

    // Ones count of the rebuilt vector; range 0..8 always fits in 4 bits.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + 4'(v[i]);
        end
        return cnt;
    endfunction

    assign idx      = in_code[3:1];
    assign all_zero = in_code[0];
    assign accept   = in_valid && in_ready && (state == COLLECT);

    // Next accumulator and sticky error values including the current word.
    always_comb begin
        acc_nxt       = acc;
        order_err_nxt = order_err;
        zero_err_nxt  = zero_err;
        if (!all_zero) begin
            acc_nxt = acc | (8'b1 << idx);
            if ((CHECK_ORDER != 0) && !first && (idx >= prev_idx)) begin
                order_err_nxt = 1'b1;
            end
        end else if (!(first && in_last)) begin
            zero_err_nxt = 1'b1;
        end
    end

    // Frame collection / result hold state machine with registered handshakes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= COLLECT;
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            out_vec       <= 8'd0;
            out_count     <= 4'd0;
            out_order_err <= 1'b0;
            out_zero_err  <= 1'b0;
            acc           <= 8'd0;
            order_err     <= 1'b0;
            zero_err      <= 1'b0;
            prev_idx      <= 3'd0;
            first         <= 1'b1;
        end else begin
            case (state)
                COLLECT: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        acc       <= acc_nxt;
                        order_err <= order_err_nxt;
                        zero_err  <= zero_err_nxt;
                        first     <= 1'b0;
                        if (!all_zero) begin
                            prev_idx <= idx;
                        end
                        if (in_last) begin
                            out_vec       <= acc_nxt;
                            out_count     <= popcount8(acc_nxt);
                            out_order_err <= order_err_nxt;
                            out_zero_err  <= zero_err_nxt;
                            out_valid     <= 1'b1;
                            in_ready      <= 1'b0;
                            state         <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= COLLECT;
                        acc       <= 8'd0;
                        order_err <= 1'b0;
                        zero_err  <= 1'b0;
                        prev_idx  <= 3'd0;
                        first     <= 1'b1;
                    end
                end
                default: begin
                    state    <= COLLECT;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_code_decoder.sv
// Directed bench for prio_code_decoder, with order checking on and off.
module tb_prio_code_decoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_code;
    logic       in_last;
    logic       out_ready;

    logic       in_ready,  in_ready0;
    logic       out_valid, out_valid0;
    logic [7:0] out_vec,   out_vec0;
    logic [3:0] out_count, out_count0;
    logic       out_order_err, out_order_err0;
    logic       out_zero_err,  out_zero_err0;

    int tests;
    int fails;

    prio_code_decoder #(.CHECK_ORDER(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_vec(out_vec), .out_count(out_count),
        .out_order_err(out_order_err), .out_zero_err(out_zero_err)
    );

    prio_code_decoder #(.CHECK_ORDER(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_code(in_code), .in_last(in_last), .out_valid(out_valid0),
        .out_ready(out_ready), .out_vec(out_vec0), .out_count(out_count0),
        .out_order_err(out_order_err0), .out_zero_err(out_zero_err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              n;
        logic [0:7][3:0] codes;
        logic [7:0]      vec;
        logic [3:0]      cnt;
        logic            oerr;
        logic            zerr;
        logic            oerr0;
    } frame_t;

    frame_t tbl [8];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [3:0] code, input logic last);
        int cyc;
        in_valid = 1'b1;
        in_code  = code;
        in_last  = last;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("in_ready_wait", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_code  = 4'h0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [0:7][3:0] codes);
        for (int k = 0; k < n; k++) begin
            send_word(codes[k], (k == n - 1));
        end
    endtask

    // Result must be valid immediately after the last-word edge.
    task automatic check_result(input string nm, input logic [7:0] vec, input logic [3:0] cnt,
                                input logic oerr, input logic zerr, input logic oerr0);
        chk({nm, "_valid"},  int'(out_valid), 1);
        chk({nm, "_vec"},    int'(out_vec), int'(vec));
        chk({nm, "_count"},  int'(out_count), int'(cnt));
        chk({nm, "_oerr"},   int'(out_order_err), int'(oerr));
        chk({nm, "_zerr"},   int'(out_zero_err), int'(zerr));
        chk({nm, "_rdy0"},   int'(in_ready), 0);
        chk({nm, "_vec0"},   int'(out_vec0), int'(vec));
        chk({nm, "_oerr0"},  int'(out_order_err0), int'(oerr0));
        chk({nm, "_zerr0"},  int'(out_zero_err0), int'(zerr));
    endtask

    task automatic drain(input string nm);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, "_valid_clr"}, int'(out_valid), 0);
        chk({nm, "_rdy_back"},  int'(in_ready), 1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_code = 4'h0;
        in_last = 1'b0;
        out_ready = 1'b0;

        tbl[0] = '{3, {4'hE, 4'h8, 4'h0, 20'h0},                         8'h91, 4'd3, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1, {4'h1, 28'h0},                                     8'h00, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{2, {4'h4, 4'hA, 24'h0},                               8'h24, 4'd2, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{2, {4'hC, 4'h1, 24'h0},                               8'h40, 4'd1, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{2, {4'hA, 4'hA, 24'h0},                               8'h20, 4'd1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{8, {4'hE, 4'hC, 4'hA, 4'h8, 4'h6, 4'h4, 4'h2, 4'h0},  8'hFF, 4'd8, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{2, {4'h1, 4'h6, 24'h0},                               8'h08, 4'd1, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{3, {4'h6, 4'h6, 4'hE, 20'h0},                         8'h88, 4'd2, 1'b1, 1'b0, 1'b0};

        // Reset state
        tick();
        tick();
        chk("rst_in_ready",  int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_vec",   int'(out_vec), 0);
        chk("rst_out_count", int'(out_count), 0);
        chk("rst_oerr",      int'(out_order_err), 0);
        chk("rst_zerr",      int'(out_zero_err), 0);
        rst_n = 1'b1;
        tick();
        chk("rel_in_ready", int'(in_ready), 1);

        // Table frames; out_ready held high while collecting must have no effect
        for (int t = 0; t < 8; t++) begin
            out_ready = 1'b1;
            send_frame(tbl[t].n, tbl[t].codes);
            out_ready = 1'b0;
            check_result($sformatf("frame%0d", t), tbl[t].vec, tbl[t].cnt,
                         tbl[t].oerr, tbl[t].zerr, tbl[t].oerr0);
            drain($sformatf("frame%0d", t));
        end

        // Full frame with output stall; inputs offered during the stall are ignored
        send_frame(8, {4'hE, 4'hC, 4'hA, 4'h8, 4'h6, 4'h4, 4'h2, 4'h0});
        in_valid = 1'b1;
        in_code  = 4'h1;
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_vec",   int'(out_vec), 8'hFF);
            chk("stall_count", int'(out_count), 8);
            chk("stall_rdy",   int'(in_ready), 0);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_code  = 4'h0;
        chk("stall_vec_end", int'(out_vec), 8'hFF);
        drain("stall");
        send_frame(1, {4'h2, 28'h0});
        check_result("after_stall", 8'h02, 4'd1, 1'b0, 1'b0, 1'b0);
        drain("after_stall");

        // Reset during COLLECT discards the partial frame
        send_word(4'hE, 1'b0);
        rst_n = 1'b0;
        tick();
        chk("rstc_in_ready",  int'(in_ready), 0);
        chk("rstc_out_valid", int'(out_valid), 0);
        chk("rstc_out_vec",   int'(out_vec), 0);
        chk("rstc_out_count", int'(out_count), 0);
        rst_n = 1'b1;
        tick();
        chk("rstc_rel_rdy", int'(in_ready), 1);
        send_frame(1, {4'h2, 28'h0});
        check_result("rstc_frame", 8'h02, 4'd1, 1'b0, 1'b0, 1'b0);

        // Reset during HOLD drops the pending result
        rst_n = 1'b0;
        tick();
        chk("rsth_out_valid", int'(out_valid), 0);
        chk("rsth_out_vec",   int'(out_vec), 0);
        rst_n = 1'b1;
        tick();
        chk("rsth_rel_rdy", int'(in_ready), 1);
        send_frame(2, {4'h6, 4'h4, 24'h0});
        check_result("rsth_frame", 8'h0C, 4'd2, 1'b0, 1'b0, 1'b0);
        drain("rsth_frame");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
